vga_timing_monitor: RTL

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_timing_monitor.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: measures Hsync/Vsync against the configured timing,
// locks onto a valid frame sequence, checksums the visible pixels of each
// frame and flags sticky horizontal/vertical timing errors.
module vga_timing_monitor #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [3:0]  vgaRed,
    input  logic [3:0]  vgaGreen,
    input  logic [3:0]  vgaBlue,
    input  logic        err_clr,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_cnt,
    output logic        err_h,
    output logic        err_v
);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    localparam logic [11:0] H_SYNC_W   = 12'(H_SYNC);
    localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
    localparam logic [10:0] H_ACT_LO   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] V_SYNC_W   = 11'(V_SYNC);
    localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
    localparam logic [9:0]  V_ACT_LO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_ACT_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    state_t      state_q, state_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [10:0] h_width_q, h_width_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        locked_q, locked_d;
    logic        frame_done_q, frame_done_d;
    logic        err_h_q, err_h_d;
    logic        err_v_q, err_v_d;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic [10:0] h_pos;
    logic [9:0]  v_pos;
    logic        chk_en, active;
    logic        h_bad, v_bad, h_err, v_err, any_err;
    logic [11:0] rgb;

    // Sync edge detection, pixel position and timing checks for this sample.
    // h_pos/v_pos are the counter values after this sample's update, so a
    // 96-pixel sync pulse measures as 96 and the first pixel after the
    // hsync fall is position 0.
    always_comb begin
        hs_fall = pix_ce & hs_q & ~Hsync;
        hs_rise = pix_ce & ~hs_q & Hsync;
        vs_fall = pix_ce & vs_q & ~Vsync;
        vs_rise = pix_ce & ~vs_q & Vsync;

        h_pos = h_cnt_q;
        if (hs_fall) begin
            h_pos = '0;
        end else if (h_cnt_q != '1) begin
            h_pos = h_cnt_q + 11'd1;
        end

        v_pos = v_cnt_q;
        if (vs_fall) begin
            v_pos = '0;
        end else if (hs_fall && (v_cnt_q != '1)) begin
            v_pos = v_cnt_q + 10'd1;
        end

        hs_d      = pix_ce ? Hsync : hs_q;
        vs_d      = pix_ce ? Vsync : vs_q;
        h_cnt_d   = pix_ce ? h_pos : h_cnt_q;
        v_cnt_d   = pix_ce ? v_pos : v_cnt_q;
        h_width_d = hs_rise ? h_pos : h_width_q;

        h_bad = (hs_fall & (({1'b0, h_width_q} != H_SYNC_W) |
                            (({1'b0, h_cnt_q} + 12'd1) != H_TOTAL_W)))
              | (pix_ce & (h_pos == '1));
        v_bad = (vs_rise & ({1'b0, v_pos} != V_SYNC_W))
              | (vs_fall & (({1'b0, v_cnt_q} + 11'd1) != V_TOTAL_W))
              | (pix_ce & (v_pos == '1));

        chk_en  = (state_q != SEARCH);
        h_err   = chk_en & h_bad;
        v_err   = chk_en & v_bad;
        any_err = h_err | v_err;

        active = pix_ce
               & (h_pos >= H_ACT_LO) & (h_pos <= H_ACT_HI)
               & (v_pos >= V_ACT_LO) & (v_pos <= V_ACT_HI);

        rgb   = {vgaRed, vgaGreen, vgaBlue};
        acc_d = acc_q;
        if (vs_fall) begin
            acc_d = '0;
        end else if (chk_en && active) begin
            acc_d = acc_q + {4'b0, rgb};
        end
    end

    // Lock state machine, frame reporting and sticky error flags.
    // A timing error always wins over a frame completion on the same sample.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        frame_sum_d  = frame_sum_q;
        frame_cnt_d  = frame_cnt_q;
        err_h_d      = (err_h_q & ~err_clr) | h_err;
        err_v_d      = (err_v_q & ~err_clr) | v_err;

        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (any_err) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    frame_sum_d  = acc_q;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            h_width_q    <= '0;
            acc_q        <= '0;
            frame_sum_q  <= '0;
            frame_cnt_q  <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_h_q      <= 1'b0;
            err_v_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            h_width_q    <= h_width_d;
            acc_q        <= acc_d;
            frame_sum_q  <= frame_sum_d;
            frame_cnt_q  <= frame_cnt_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            err_h_q      <= err_h_d;
            err_v_q      <= err_v_d;
        end
    end

    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_h      = err_h_q;
    assign err_v      = err_v_q;

endmodule
